// File: rtl/noc_config_pkg.sv
// ----------------------------------------------------------------------------
// noc_config_pkg
//   Network-on-chip configuration shared by every router stage: the
//   noc_config struct and the default configuration used when a stage is
//   instantiated without an override.
// ----------------------------------------------------------------------------
package noc_config_pkg;

  typedef struct packed {
    int unsigned data_width;        // flit payload width in bits
    int unsigned virtual_channels;  // number of VCs per link
    int unsigned input_fifo_depth;  // flits buffered per VC at a router input
  } noc_config;

  localparam noc_config NOC_DEFAULT_CONFIG = '{
    data_width:       32'd16,
    virtual_channels: 32'd3,
    input_fifo_depth: 32'd8
  };

endpackage

// File: rtl/noc_flit_pkg.sv
// ----------------------------------------------------------------------------
// noc_flit_pkg
//   Flit-level types shared by the router stages: the flit record
//   (framing bits + payload, sized from the default configuration) and the
//   per-VC packet framing state.
// ----------------------------------------------------------------------------
package noc_flit_pkg;

  import noc_config_pkg::*;

  localparam int unsigned NOC_FLIT_DATA_W = NOC_DEFAULT_CONFIG.data_width;

  typedef struct packed {
    logic                       head;
    logic                       tail;
    logic [NOC_FLIT_DATA_W-1:0] data;
  } noc_flit;

  // IDLE: between packets, BUSY: inside a packet (head seen, tail not yet)
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } noc_vc_frame_state;

endpackage

// File: rtl/noc_vc_fifo.sv
// ----------------------------------------------------------------------------
// noc_vc_fifo
//   Single-VC flit FIFO. Pointers wrap explicitly at DEPTH-1 so DEPTH need not
//   be a power of two. Full/empty flags are flops so the router input sees
//   them straight from registers.
//   Optional macro NOC_VC_BUFFER_STATUS_EN adds the occupancy and
//   almost-full outputs.
// Ports
//   clk, rst_n  clock, async active-low reset (pointers/count/flags only)
//   push_i      write wdata_i (ignored while full)
//   wdata_i     entry to store
//   pop_i       drop the head entry (ignored while empty)
//   rdata_o     head entry
//   full_o      count == DEPTH
//   empty_o     count == 0
//   count_o     occupancy               (NOC_VC_BUFFER_STATUS_EN only)
//   afull_o     count >= DEPTH-1        (NOC_VC_BUFFER_STATUS_EN only)
// ----------------------------------------------------------------------------
module noc_vc_fifo #(
  parameter  int unsigned WIDTH = 18,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTRW  = (DEPTH > 32'd1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNTW  = $clog2(DEPTH + 32'd1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
`ifdef NOC_VC_BUFFER_STATUS_EN
  ,
  output logic [CNTW-1:0]  count_o,
  output logic             afull_o
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] ptr);
    if (ptr == PTRW'(DEPTH - 32'd1)) begin
      return '0;
    end else begin
      return ptr + PTRW'(1'b1);
    end
  endfunction

  assign do_push_s = push_i && !full_q;
  assign do_pop_s  = pop_i && !empty_q;

  // Next pointers, occupancy and flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CNTW'(1'b1);
    end else if (!do_push_s && do_pop_s) begin
      count_d = count_q - CNTW'(1'b1);
    end else begin
      count_d = count_q;
    end
    full_d  = (count_d == CNTW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Flit storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

`ifdef NOC_VC_BUFFER_STATUS_EN
  logic afull_q;

  // Almost-full flag, registered from next occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (count_d >= CNTW'(DEPTH - 32'd1));
    end
  end

  assign count_o = count_q;
  assign afull_o = afull_q;
`endif

endmodule

// File: rtl/noc_input_vc_buffer.sv
// ----------------------------------------------------------------------------
// noc_input_vc_buffer
//   Router input stage: one FIFO per virtual channel, head-of-queue flit of
//   every VC presented to route/arbitration, and a per-VC head/tail framing
//   checker with a sticky error flag. Flits addressed to a non-existent VC
//   are silently ignored.
//   Optional macro NOC_VC_BUFFER_STATUS_EN adds o_count / o_almost_full.
// Ports
//   clk, rst_n        clock, async active-low reset
//   i_valid/i_vc      incoming flit valid and target VC
//   i_head/i_tail     incoming framing bits
//   i_data            incoming payload
//   o_ready[VC]       per-VC space available (from flops)
//   o_valid[VC]       per-VC head-of-queue valid
//   o_head/o_tail[VC] per-VC head-of-queue framing bits
//   o_data            per-VC payload, VC v at [v*DW +: DW]
//   i_ready[VC]       per-VC downstream pop
//   o_protocol_error  per-VC sticky framing error
//   o_count           per-VC occupancy, CNTW bits each (status build)
//   o_almost_full     per-VC count >= DEPTH-1         (status build)
// ----------------------------------------------------------------------------
module noc_input_vc_buffer
  import noc_config_pkg::*;
  import noc_flit_pkg::*;
#(
  parameter  noc_config   CONFIG = NOC_DEFAULT_CONFIG,
  localparam int unsigned DW     = CONFIG.data_width,
  localparam int unsigned VC     = CONFIG.virtual_channels,
  localparam int unsigned DEPTH  = CONFIG.input_fifo_depth,
  localparam int unsigned VCW    = (VC > 32'd1) ? $clog2(VC) : 1,
  localparam int unsigned CNTW   = $clog2(DEPTH + 32'd1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [VCW-1:0]   i_vc,
  input  logic             i_head,
  input  logic             i_tail,
  input  logic [DW-1:0]    i_data,
  output logic [VC-1:0]    o_ready,
  output logic [VC-1:0]    o_valid,
  output logic [VC-1:0]    o_head,
  output logic [VC-1:0]    o_tail,
  output logic [VC*DW-1:0] o_data,
  input  logic [VC-1:0]    i_ready,
  output logic [VC-1:0]    o_protocol_error
`ifdef NOC_VC_BUFFER_STATUS_EN
  ,
  output logic [VC*CNTW-1:0] o_count,
  output logic [VC-1:0]      o_almost_full
`endif
);

  if (DEPTH < 32'd2 || VC < 32'd1) begin : g_cfg_check
    $error("noc_input_vc_buffer: input_fifo_depth must be >= 2 and virtual_channels >= 1");
  end

  for (genvar v = 0; v < VC; v++) begin : g_vc
    logic [DW+1:0]     rd_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    noc_vc_frame_state frame_q;
    logic              err_q;

    // An out-of-range i_vc matches no generated VC, so it is dropped here.
    assign push_s = i_valid && (i_vc == VCW'(v)) && !full_s;
    assign pop_s  = i_ready[v] && !empty_s;

    noc_vc_fifo #(
      .WIDTH (DW + 32'd2),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .wdata_i ({i_head, i_tail, i_data}),
      .pop_i   (pop_s),
      .rdata_o (rd_s),
      .full_o  (full_s),
      .empty_o (empty_s)
`ifdef NOC_VC_BUFFER_STATUS_EN
      ,
      .count_o (o_count[v*CNTW +: CNTW]),
      .afull_o (o_almost_full[v])
`endif
    );

    // Framing checker: advances on accepted flits only; a bad flit is still stored
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        frame_q <= IDLE;
        err_q   <= 1'b0;
      end else if (push_s) begin
        case (frame_q)
          IDLE: begin
            if (!i_head) begin
              err_q <= 1'b1;
            end else if (!i_tail) begin
              frame_q <= BUSY;
            end else begin
              frame_q <= IDLE;
            end
          end
          BUSY: begin
            if (i_head) begin
              err_q <= 1'b1;
            end else if (i_tail) begin
              frame_q <= IDLE;
            end else begin
              frame_q <= BUSY;
            end
          end
          default: begin
            frame_q <= IDLE;
          end
        endcase
      end
    end

    assign o_ready[v]          = !full_s;
    assign o_valid[v]          = !empty_s;
    assign o_head[v]           = rd_s[DW+1];
    assign o_tail[v]           = rd_s[DW];
    assign o_data[v*DW +: DW]  = rd_s[DW-1:0];
    assign o_protocol_error[v] = err_q;
  end

endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// ----------------------------------------------------------------------------
// tb_noc_input_vc_buffer
//   Two DUTs (DEPTH=8 and DEPTH=3, three VCs, 16-bit data) share the upstream
//   flit stream and have independent pop controls. A queue-per-VC reference
//   model holds the expected contents and framing state; a monitor compares
//   every VC of both DUTs against it on each falling clock edge, and checks
//   the reset values directly whenever reset is asserted.
// ----------------------------------------------------------------------------
module tb_noc_input_vc_buffer;
  import noc_config_pkg::*;

  localparam noc_config CFG_D8 = '{data_width: 32'd16, virtual_channels: 32'd3, input_fifo_depth: 32'd8};
  localparam noc_config CFG_D3 = '{data_width: 32'd16, virtual_channels: 32'd3, input_fifo_depth: 32'd3};

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [1:0]  i_vc;
  logic        i_head;
  logic        i_tail;
  logic [15:0] i_data;
  logic [2:0]  rdy      [2];
  logic [2:0]  o_ready_w[2];
  logic [2:0]  o_valid_w[2];
  logic [2:0]  o_head_w [2];
  logic [2:0]  o_tail_w [2];
  logic [47:0] o_data_w [2];
  logic [2:0]  o_perr_w [2];
`ifdef NOC_VC_BUFFER_STATUS_EN
  logic [11:0] cnt0;
  logic [5:0]  cnt1;
  logic [2:0]  af0, af1;
`endif

  noc_input_vc_buffer #(.CONFIG(CFG_D8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_vc(i_vc), .i_head(i_head),
    .i_tail(i_tail), .i_data(i_data), .o_ready(o_ready_w[0]), .o_valid(o_valid_w[0]),
    .o_head(o_head_w[0]), .o_tail(o_tail_w[0]), .o_data(o_data_w[0]),
    .i_ready(rdy[0]), .o_protocol_error(o_perr_w[0])
`ifdef NOC_VC_BUFFER_STATUS_EN
    , .o_count(cnt0), .o_almost_full(af0)
`endif
  );

  noc_input_vc_buffer #(.CONFIG(CFG_D3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_vc(i_vc), .i_head(i_head),
    .i_tail(i_tail), .i_data(i_data), .o_ready(o_ready_w[1]), .o_valid(o_valid_w[1]),
    .o_head(o_head_w[1]), .o_tail(o_tail_w[1]), .o_data(o_data_w[1]),
    .i_ready(rdy[1]), .o_protocol_error(o_perr_w[1])
`ifdef NOC_VC_BUFFER_STATUS_EN
    , .o_count(cnt1), .o_almost_full(af1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected queue contents {head,tail,data} and framing per DUT/VC
  logic [17:0] mq [2][3][$];
  bit          busy_m [2][3];
  bit          err_m  [2][3];
  int          depth_m [2] = '{8, 3};

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string nm, input int i, input int v,
                       input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d vc%0d: got %h expected %h at %0t", nm, i, v, got, exp, $time);
    end
  endtask

  // Model update on each clock: accept decided from pre-edge occupancy, then pop, then push
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int v = 0; v < 3; v++) begin
          mq[i][v].delete();
          busy_m[i][v] = 1'b0;
          err_m[i][v]  = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int v = 0; v < 3; v++) begin
          bit acc;
          acc = i_valid && (int'(i_vc) == v) && (mq[i][v].size() < depth_m[i]);
          if (rdy[i][v] && mq[i][v].size() > 0) void'(mq[i][v].pop_front());
          if (acc) begin
            mq[i][v].push_back({i_head, i_tail, i_data});
            if (!busy_m[i][v]) begin
              if (!i_head) err_m[i][v] = 1'b1;
              else busy_m[i][v] = !i_tail;
            end else begin
              if (i_head) err_m[i][v] = 1'b1;
              else if (i_tail) busy_m[i][v] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Monitor: reset values while in reset, model comparison otherwise
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        for (int v = 0; v < 3; v++) begin
          check("rst_valid", i, v, 32'(o_valid_w[i][v]), 32'd0);
          check("rst_ready", i, v, 32'(o_ready_w[i][v]), 32'd1);
          check("rst_perr",  i, v, 32'(o_perr_w[i][v]),  32'd0);
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int v = 0; v < 3; v++) begin
          bit exp_valid;
          exp_valid = (mq[i][v].size() != 0);
          check("valid", i, v, 32'(o_valid_w[i][v]), 32'(exp_valid));
          check("ready", i, v, 32'(o_ready_w[i][v]), 32'(mq[i][v].size() < depth_m[i]));
          check("perr",  i, v, 32'(o_perr_w[i][v]),  32'(err_m[i][v]));
          if (exp_valid) begin
            check("flit", i, v,
                  32'({o_head_w[i][v], o_tail_w[i][v], o_data_w[i][v*16 +: 16]}),
                  32'(mq[i][v][0]));
          end
        end
      end
`ifdef NOC_VC_BUFFER_STATUS_EN
      for (int v = 0; v < 3; v++) begin
        check("count", 0, v, 32'(cnt0[v*4 +: 4]), 32'(mq[0][v].size()));
        check("count", 1, v, 32'(cnt1[v*2 +: 2]), 32'(mq[1][v].size()));
        check("afull", 0, v, 32'(af0[v]), 32'(mq[0][v].size() >= 7));
        check("afull", 1, v, 32'(af1[v]), 32'(mq[1][v].size() >= 2));
      end
`endif
    end
  end

  task automatic drive(input bit vld, input int vc, input bit h, input bit t);
    i_valid = vld;
    i_vc    = 2'(vc);
    i_head  = h;
    i_tail  = t;
    i_data  = 16'($urandom);
  endtask

  task automatic set_rdy(input logic [2:0] r);
    rdy[0] = r;
    rdy[1] = r;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 0, 1'b0, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    set_rdy(3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single head&tail flit on VC0
    @(negedge clk); drive(1'b1, 0, 1'b1, 1'b1);
    idle_cycles(2);

    // fill VC1 past full with no pops, then pop once while pushing (dropped), then refill
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); drive(1'b1, 1, k == 0, 1'b0);
    end
    @(negedge clk); set_rdy(3'b010); drive(1'b1, 1, 1'b0, 1'b0);
    @(negedge clk); set_rdy(3'b000); drive(1'b1, 1, 1'b0, 1'b1);
    idle_cycles(2);

    // drain everything
    set_rdy(3'b111);
    idle_cycles(12);

    // back-to-back push and pop on VC0, occupancy stays at 1 and pointers wrap
    for (int k = 0; k < 21; k++) begin
      @(negedge clk); drive(1'b1, 0, 1'b1, 1'b1);
    end
    idle_cycles(3);

    // interleave VC0/VC1, pop only VC1; include out-of-range VC 3
    set_rdy(3'b010);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk); drive(1'b1, (k % 2 == 0) ? 0 : 1, 1'b1, 1'b1);
    end
    @(negedge clk); drive(1'b1, 3, 1'b1, 1'b1);
    @(negedge clk); drive(1'b1, 3, 1'b0, 1'b0);
    idle_cycles(3);
    set_rdy(3'b111);
    idle_cycles(12);

    // framing errors from a clean reset
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    set_rdy(3'b000);
    @(negedge clk); drive(1'b1, 0, 1'b0, 1'b1);   // no head on idle VC0
    @(negedge clk); drive(1'b1, 1, 1'b1, 1'b0);   // open packet on VC1
    @(negedge clk); drive(1'b1, 1, 1'b1, 1'b0);   // head while busy
    @(negedge clk); drive(1'b1, 1, 1'b0, 1'b1);
    idle_cycles(4);
    set_rdy(3'b111);
    idle_cycles(6);

    // reset in the middle of a 5-flit packet
    set_rdy(3'b000);
    @(negedge clk); drive(1'b1, 2, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(1'b1, 2, 1'b0, 1'b0);
    end
    @(negedge clk); drive(1'b1, 0, 1'b0, 1'b0);   // one more framing error before reset
    @(negedge clk); drive(1'b0, 0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      drive(($urandom % 4) != 0, int'($urandom % 4), ($urandom % 3) == 0, ($urandom % 3) == 0);
      rdy[0] = 3'($urandom);
      rdy[1] = 3'($urandom);
    end
    idle_cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
